segre_id_stage: RTL and testbench

SEGRE_ID_STAGE -- requirements
Module: segre_id_stage

---
 rtl/segre_id_stage.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_segre_id_stage.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/segre_id_stage.sv
// segre_id_stage: RV32I decode stage with integrated register file.
// Decode results are registered and only update on an ID_STATE edge.

package segre_pkg;
    typedef enum logic [2:0] {
        IF_STATE,
        ID_STATE,
        EX_STATE,
        MEM_STATE,
        WB_STATE
    } fsm_state_e;
endpackage

module segre_id_stage
    import segre_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int ADDR_SIZE = 32,
    parameter int REG_COUNT = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  fsm_state_e           fsm_state_i,
    input  logic [WORD_SIZE-1:0] instr_i,
    input  logic [ADDR_SIZE-1:0] pc_i,
    input  logic                 rf_we_i,
    input  logic [4:0]           rf_waddr_i,
    input  logic [WORD_SIZE-1:0] rf_wdata_i,
    output logic [WORD_SIZE-1:0] rs1_data_o,
    output logic [WORD_SIZE-1:0] rs2_data_o,
    output logic [WORD_SIZE-1:0] imm_o,
    output logic [ADDR_SIZE-1:0] pc_o,
    output logic [4:0]           rd_o,
    output logic [3:0]           alu_op_o,
    output logic                 alu_src_a_o,
    output logic                 alu_src_b_o,
    output logic                 rf_we_o,
    output logic                 mem_rd_o,
    output logic                 mem_wr_o,
    output logic                 branch_o,
    output logic                 jump_o,
    output logic                 illegal_o,
    output logic [1:0]           mem_size_o,
    output logic                 mem_unsigned_o,
    output logic [2:0]           br_type_o
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    logic [WORD_SIZE-1:0] rf_q [REG_COUNT];

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic [31:0] imm_i32, imm_s32, imm_b32, imm_u32, imm_j32;
    logic [31:0] imm32;
    logic        ill;

    logic [WORD_SIZE-1:0] rs1_data_d, rs2_data_d, imm_d;
    logic [3:0]           alu_op_d;
    logic                 alu_src_a_d, alu_src_b_d;
    logic                 rf_we_d, mem_rd_d, mem_wr_d;
    logic                 branch_d, jump_d;
    logic [1:0]           mem_size_d;
    logic                 mem_unsigned_d;
    logic [2:0]           br_type_d;

    logic [WORD_SIZE-1:0] rs1_data_q, rs2_data_q, imm_q;
    logic [ADDR_SIZE-1:0] pc_q;
    logic [4:0]           rd_q;
    logic [3:0]           alu_op_q;
    logic                 alu_src_a_q, alu_src_b_q;
    logic                 rf_we_q, mem_rd_q, mem_wr_q;
    logic                 branch_q, jump_q, illegal_q;
    logic [1:0]           mem_size_q;
    logic                 mem_unsigned_q;
    logic [2:0]           br_type_q;

    assign opcode  = instr_i[6:0];
    assign funct3  = instr_i[14:12];
    assign funct7  = instr_i[31:25];
    assign rs2_idx = instr_i[24:20];

    assign imm_i32 = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                      instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u32 = {instr_i[31:12], 12'b0};
    assign imm_j32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                      instr_i[20], instr_i[30:21], 1'b0};

    // Combinational decode of the instruction presented by fetch
    always_comb begin
        rs1_idx        = instr_i[19:15];
        imm32          = '0;
        ill            = 1'b0;
        alu_op_d       = ALU_ADD;
        alu_src_a_d    = 1'b0;
        alu_src_b_d    = 1'b0;
        rf_we_d        = 1'b0;
        mem_rd_d       = 1'b0;
        mem_wr_d       = 1'b0;
        branch_d       = 1'b0;
        jump_d         = 1'b0;
        mem_size_d     = 2'd0;
        mem_unsigned_d = 1'b0;
        br_type_d      = 3'd0;
        case (opcode)
            OPC_LUI: begin
                rs1_idx     = 5'd0;
                imm32       = imm_u32;
                alu_src_b_d = 1'b1;
                rf_we_d     = 1'b1;
            end
            OPC_AUIPC: begin
                imm32       = imm_u32;
                alu_src_a_d = 1'b1;
                alu_src_b_d = 1'b1;
                rf_we_d     = 1'b1;
            end
            OPC_JAL: begin
                imm32       = imm_j32;
                alu_src_a_d = 1'b1;
                alu_src_b_d = 1'b1;
                rf_we_d     = 1'b1;
                jump_d      = 1'b1;
            end
            OPC_JALR: begin
                imm32       = imm_i32;
                alu_src_b_d = 1'b1;
                rf_we_d     = 1'b1;
                jump_d      = 1'b1;
                ill         = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                imm32     = imm_b32;
                alu_op_d  = ALU_SUB;
                branch_d  = 1'b1;
                br_type_d = funct3;
                ill       = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OPC_LOAD: begin
                imm32          = imm_i32;
                alu_src_b_d    = 1'b1;
                rf_we_d        = 1'b1;
                mem_rd_d       = 1'b1;
                mem_size_d     = funct3[1:0];
                mem_unsigned_d = funct3[2];
                ill            = (funct3[1:0] == 2'b11) ||
                                 (funct3 == 3'b110);
            end
            OPC_STORE: begin
                imm32          = imm_s32;
                alu_src_b_d    = 1'b1;
                mem_wr_d       = 1'b1;
                mem_size_d     = funct3[1:0];
                mem_unsigned_d = funct3[2];
                ill            = funct3[2] || (funct3[1:0] == 2'b11);
            end
            OPC_OPIMM: begin
                imm32       = imm_i32;
                alu_src_b_d = 1'b1;
                rf_we_d     = 1'b1;
                case (funct3)
                    3'b000: alu_op_d = ALU_ADD;
                    3'b001: begin
                        alu_op_d = ALU_SLL;
                        ill      = (funct7 != F7_BASE);
                    end
                    3'b010: alu_op_d = ALU_SLT;
                    3'b011: alu_op_d = ALU_SLTU;
                    3'b100: alu_op_d = ALU_XOR;
                    3'b101: begin
                        alu_op_d = instr_i[30] ? ALU_SRA : ALU_SRL;
                        ill      = (funct7 != F7_BASE) &&
                                   (funct7 != F7_ALT);
                    end
                    3'b110: alu_op_d = ALU_OR;
                    default: alu_op_d = ALU_AND;
                endcase
            end
            OPC_OP: begin
                rf_we_d = 1'b1;
                case (funct3)
                    3'b000: alu_op_d = instr_i[30] ? ALU_SUB : ALU_ADD;
                    3'b001: alu_op_d = ALU_SLL;
                    3'b010: alu_op_d = ALU_SLT;
                    3'b011: alu_op_d = ALU_SLTU;
                    3'b100: alu_op_d = ALU_XOR;
                    3'b101: alu_op_d = instr_i[30] ? ALU_SRA : ALU_SRL;
                    3'b110: alu_op_d = ALU_OR;
                    default: alu_op_d = ALU_AND;
                endcase
                if (funct7 == F7_ALT) begin
                    ill = (funct3 != 3'b000) && (funct3 != 3'b101);
                end else begin
                    ill = (funct7 != F7_BASE);
                end
            end
            default: ill = 1'b1;
        endcase
        if (ill) begin
            rf_we_d  = 1'b0;
            mem_rd_d = 1'b0;
            mem_wr_d = 1'b0;
            branch_d = 1'b0;
            jump_d   = 1'b0;
        end
        imm_d      = WORD_SIZE'($signed(imm32));
        rs1_data_d = (rs1_idx == 5'd0) ? '0 : rf_q[rs1_idx];
        rs2_data_d = (rs2_idx == 5'd0) ? '0 : rf_q[rs2_idx];
    end

    // Register file: write-back port active only in WB_STATE, x0 stays zero
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                rf_q[i] <= '0;
            end
        end else if (fsm_state_i == WB_STATE && rf_we_i &&
                     rf_waddr_i != 5'd0) begin
            rf_q[rf_waddr_i] <= rf_wdata_i;
        end
    end

    // Output registers: capture decode in ID_STATE, hold otherwise
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rs1_data_q     <= '0;
            rs2_data_q     <= '0;
            imm_q          <= '0;
            pc_q           <= '0;
            rd_q           <= '0;
            alu_op_q       <= '0;
            alu_src_a_q    <= 1'b0;
            alu_src_b_q    <= 1'b0;
            rf_we_q        <= 1'b0;
            mem_rd_q       <= 1'b0;
            mem_wr_q       <= 1'b0;
            branch_q       <= 1'b0;
            jump_q         <= 1'b0;
            illegal_q      <= 1'b0;
            mem_size_q     <= '0;
            mem_unsigned_q <= 1'b0;
            br_type_q      <= '0;
        end else if (fsm_state_i == ID_STATE) begin
            rs1_data_q     <= rs1_data_d;
            rs2_data_q     <= rs2_data_d;
            imm_q          <= imm_d;
            pc_q           <= pc_i;
            rd_q           <= instr_i[11:7];
            alu_op_q       <= alu_op_d;
            alu_src_a_q    <= alu_src_a_d;
            alu_src_b_q    <= alu_src_b_d;
            rf_we_q        <= rf_we_d;
            mem_rd_q       <= mem_rd_d;
            mem_wr_q       <= mem_wr_d;
            branch_q       <= branch_d;
            jump_q         <= jump_d;
            illegal_q      <= ill;
            mem_size_q     <= mem_size_d;
            mem_unsigned_q <= mem_unsigned_d;
            br_type_q      <= br_type_d;
        end
    end

    assign rs1_data_o     = rs1_data_q;
    assign rs2_data_o     = rs2_data_q;
    assign imm_o          = imm_q;
    assign pc_o           = pc_q;
    assign rd_o           = rd_q;
    assign alu_op_o       = alu_op_q;
    assign alu_src_a_o    = alu_src_a_q;
    assign alu_src_b_o    = alu_src_b_q;
    assign rf_we_o        = rf_we_q;
    assign mem_rd_o       = mem_rd_q;
    assign mem_wr_o       = mem_wr_q;
    assign branch_o       = branch_q;
    assign jump_o         = jump_q;
    assign illegal_o      = illegal_q;
    assign mem_size_o     = mem_size_q;
    assign mem_unsigned_o = mem_unsigned_q;
    assign br_type_o      = br_type_q;

endmodule

// File: tb/tb_segre_id_stage.sv
// tb_segre_id_stage: directed table, hand sequences and random decode
// checked against a behavioural RV32I decode model.

module tb_segre_id_stage;
    import segre_pkg::*;

    typedef struct packed {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [3:0]  op;
        logic        sa;
        logic        sb;
        logic        we;
        logic        mr;
        logic        mw;
        logic        br;
        logic        jp;
        logic        il;
        logic [1:0]  sz;
        logic        un;
        logic [2:0]  bt;
    } out_t;

    // mask bits: 0 rs1,1 rs2,2 imm,3 rd,4 op,5 srcb,6 rfwe,7 memwr,8 ill,9 size
    typedef struct {
        fsm_state_e  st;
        logic [31:0] instr;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [9:0]  m;
        logic [31:0] e_rs1;
        logic [31:0] e_rs2;
        logic [31:0] e_imm;
        logic [4:0]  e_rd;
        logic [3:0]  e_op;
        logic        e_sb;
        logic        e_we;
        logic        e_mw;
        logic        e_il;
        logic [1:0]  e_sz;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    fsm_state_e  st;
    logic [31:0] instr, pc, wdata;
    logic        we;
    logic [4:0]  waddr;

    logic [31:0] rs1_data, rs2_data, imm, pc_q;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        src_a, src_b, rf_we, mem_rd, mem_wr;
    logic        branch, jump, illegal, mem_uns;
    logic [1:0]  mem_size;
    logic [2:0]  br_type;

    out_t        dut;
    out_t        mout;
    logic [31:0] mrf [32];
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    segre_id_stage dut_i (
        .clk_i         (clk),
        .rst_i         (rst),
        .fsm_state_i   (st),
        .instr_i       (instr),
        .pc_i          (pc),
        .rf_we_i       (we),
        .rf_waddr_i    (waddr),
        .rf_wdata_i    (wdata),
        .rs1_data_o    (rs1_data),
        .rs2_data_o    (rs2_data),
        .imm_o         (imm),
        .pc_o          (pc_q),
        .rd_o          (rd),
        .alu_op_o      (alu_op),
        .alu_src_a_o   (src_a),
        .alu_src_b_o   (src_b),
        .rf_we_o       (rf_we),
        .mem_rd_o      (mem_rd),
        .mem_wr_o      (mem_wr),
        .branch_o      (branch),
        .jump_o        (jump),
        .illegal_o     (illegal),
        .mem_size_o    (mem_size),
        .mem_unsigned_o(mem_uns),
        .br_type_o     (br_type)
    );

    assign dut = {rs1_data, rs2_data, imm, pc_q, rd, alu_op, src_a, src_b,
                  rf_we, mem_rd, mem_wr, branch, jump, illegal, mem_size,
                  mem_uns, br_type};

    // Behavioural decode derived from the RV32I encoding rules
    function automatic out_t ref_decode(logic [31:0] ins, logic [31:0] p);
        out_t o;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [31:0] sx, ii, si, bi, ui, ji;
        logic [3:0] base_op [8];
        logic alt, legal;
        base_op = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        opc = ins[6:0];
        f3  = ins[14:12];
        f7  = ins[31:25];
        alt = (f7 == 7'h20);
        sx  = {32{ins[31]}};
        ii  = 32'($signed(ins) >>> 20);
        si  = (sx << 12) | {20'b0, ins[31:25], ins[11:7]};
        bi  = (sx << 12) | ({31'b0, ins[7]} << 11) |
              ({26'b0, ins[30:25]} << 5) | ({28'b0, ins[11:8]} << 1);
        ui  = ins & 32'hFFFF_F000;
        ji  = (sx << 20) | ({24'b0, ins[19:12]} << 12) |
              ({31'b0, ins[20]} << 11) | ({22'b0, ins[30:21]} << 1);
        o = '0;
        o.pc  = p;
        o.rd  = ins[11:7];
        o.rs1 = mrf[ins[19:15]];
        o.rs2 = mrf[ins[24:20]];
        legal = 1'b1;
        if (opc == 7'h37) begin
            o.rs1 = 0; o.imm = ui; o.sb = 1; o.we = 1;
        end else if (opc == 7'h17) begin
            o.imm = ui; o.sa = 1; o.sb = 1; o.we = 1;
        end else if (opc == 7'h6F) begin
            o.imm = ji; o.sa = 1; o.sb = 1; o.we = 1; o.jp = 1;
        end else if (opc == 7'h67) begin
            o.imm = ii; o.sb = 1; o.we = 1; o.jp = 1;
            legal = (f3 == 0);
        end else if (opc == 7'h63) begin
            o.imm = bi; o.op = 1; o.br = 1; o.bt = f3;
            legal = !(f3 inside {3'd2, 3'd3});
        end else if (opc == 7'h03) begin
            o.imm = ii; o.sb = 1; o.we = 1; o.mr = 1;
            o.sz = f3[1:0]; o.un = f3[2];
            legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        end else if (opc == 7'h23) begin
            o.imm = si; o.sb = 1; o.mw = 1;
            o.sz = f3[1:0]; o.un = f3[2];
            legal = f3 inside {3'd0, 3'd1, 3'd2};
        end else if (opc == 7'h13) begin
            o.imm = ii; o.sb = 1; o.we = 1;
            o.op = base_op[f3] + ((f3 == 5 && alt) ? 4'd1 : 4'd0);
            if (f3 == 1) legal = (f7 == 0);
            if (f3 == 5) legal = (f7 == 0) || alt;
        end else if (opc == 7'h33) begin
            o.we = 1;
            o.op = base_op[f3] + (((f3 == 0 || f3 == 5) && alt) ? 4'd1 : 4'd0);
            legal = (f7 == 0) || (alt && (f3 == 0 || f3 == 5));
        end else begin
            legal = 1'b0;
        end
        if (!legal) begin
            o.il = 1; o.we = 0; o.mr = 0; o.mw = 0; o.br = 0; o.jp = 0;
        end
        return o;
    endfunction

    task automatic cmp(string name, logic [150:0] got, logic [150:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, check after the edge
    task automatic step(fsm_state_e s, logic r, logic [31:0] ins,
                        logic [31:0] p, logic w, logic [4:0] wa,
                        logic [31:0] wd);
        @(negedge clk);
        st = s; rst = r; instr = ins; pc = p;
        we = w; waddr = wa; wdata = wd;
        if (r) begin
            for (int i = 0; i < 32; i++) mrf[i] = 0;
            mout = '0;
        end else if (s == WB_STATE && w && wa != 0) begin
            mrf[wa] = wd;
        end else if (s == ID_STATE) begin
            mout = ref_decode(ins, p);
        end
        @(posedge clk);
        #1;
        cmp("model", dut, mout);
    endtask

    vec_t tbl [$];
    out_t saved;

    function automatic vec_t mk(fsm_state_e s, logic [31:0] ins, logic w,
                                logic [4:0] wa, logic [31:0] wd,
                                logic [9:0] m, logic [31:0] r1,
                                logic [31:0] r2, logic [31:0] im,
                                logic [4:0] d, logic [3:0] op, logic sb,
                                logic rw, logic mw, logic il,
                                logic [1:0] sz);
        vec_t v;
        v.st = s; v.instr = ins; v.we = w; v.wa = wa; v.wd = wd; v.m = m;
        v.e_rs1 = r1; v.e_rs2 = r2; v.e_imm = im; v.e_rd = d; v.e_op = op;
        v.e_sb = sb; v.e_we = rw; v.e_mw = mw; v.e_il = il; v.e_sz = sz;
        return v;
    endfunction

    initial begin
        rst = 1; st = IF_STATE; instr = 0; pc = 0;
        we = 0; waddr = 0; wdata = 0;
        for (int i = 0; i < 32; i++) mrf[i] = 0;
        mout = '0;

        step(IF_STATE, 1, 32'h0, 32'h0, 0, 0, 0);
        cmp("reset_zero", dut, '0);

        tbl.push_back(mk(WB_STATE, 32'h0, 1, 5, 32'hDEADBEEF, 10'h000,
                         0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(ID_STATE, 32'h00500093, 0, 0, 0, 10'h17D,
                         0, 32'hDEADBEEF, 5, 1, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(ID_STATE, 32'h00528333, 0, 0, 0, 10'h17B,
                         32'hDEADBEEF, 32'hDEADBEEF, 0, 6, 0, 0, 1, 0, 0,
                         0));
        tbl.push_back(mk(WB_STATE, 32'h0, 1, 0, 32'h1234, 10'h000,
                         0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(ID_STATE, 32'h00500093, 0, 0, 0, 10'h001,
                         0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(ID_STATE, 32'hFE20AE23, 0, 0, 0, 10'h3C4,
                         0, 0, 32'hFFFFFFFC, 0, 0, 0, 0, 1, 0, 2));
        tbl.push_back(mk(ID_STATE, 32'hFFFFFFFF, 0, 0, 0, 10'h1C0,
                         0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(WB_STATE, 32'h0, 1, 8, 32'hCAFEF00D, 10'h000,
                         0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(ID_STATE, 32'h123452B7, 0, 0, 0, 10'h16D,
                         0, 0, 32'h12345000, 5, 0, 1, 1, 0, 0, 0));

        foreach (tbl[k]) begin
            vec_t v;
            v = tbl[k];
            step(v.st, 0, v.instr, 32'h100 + 32'(k * 4), v.we, v.wa, v.wd);
            if (v.m[0]) cmp("rs1", 151'(rs1_data), 151'(v.e_rs1));
            if (v.m[1]) cmp("rs2", 151'(rs2_data), 151'(v.e_rs2));
            if (v.m[2]) cmp("imm", 151'(imm), 151'(v.e_imm));
            if (v.m[3]) cmp("rd", 151'(rd), 151'(v.e_rd));
            if (v.m[4]) cmp("alu_op", 151'(alu_op), 151'(v.e_op));
            if (v.m[5]) cmp("src_b", 151'(src_b), 151'(v.e_sb));
            if (v.m[6]) cmp("rf_we", 151'(rf_we), 151'(v.e_we));
            if (v.m[7]) cmp("mem_wr", 151'(mem_wr), 151'(v.e_mw));
            if (v.m[8]) cmp("illegal", 151'(illegal), 151'(v.e_il));
            if (v.m[9]) cmp("mem_size", 151'(mem_size), 151'(v.e_sz));
            if (v.m[8] && v.e_il) begin
                cmp("ill_flags", 151'({mem_rd, branch, jump}), 151'(0));
            end
        end

        // hold in EX, reset in MEM, then x5 reads zero
        step(ID_STATE, 0, 32'h00500093, 32'h200, 0, 0, 0);
        saved = dut;
        step(EX_STATE, 0, 32'hFFFFFFFF, 32'h300, 0, 0, 0);
        cmp("hold_ex", dut, saved);
        cmp("hold_imm", 151'(imm), 151'(5));
        step(MEM_STATE, 1, 32'h00528333, 32'h304, 0, 0, 0);
        cmp("reset_mem", dut, '0);
        step(ID_STATE, 0, 32'h00528333, 32'h308, 0, 0, 0);
        cmp("x5_after_rst", 151'(rs1_data), 151'(0));

        // reset beats a concurrent write-back
        step(WB_STATE, 0, 32'h0, 32'h0, 1, 7, 32'h55AA55AA);
        step(WB_STATE, 1, 32'h0, 32'h0, 1, 7, 32'h12345678);
        step(ID_STATE, 0, 32'h00738333, 32'h40, 0, 0, 0);
        cmp("rst_over_wb", 151'(rs1_data), 151'(0));

        for (int n = 0; n < 600; n++) begin
            logic [6:0]  opcs [10];
            logic [6:0]  f7;
            logic [31:0] ins;
            int          sel;
            opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23,
                     7'h13, 7'h33, 7'h00};
            opcs[9] = 7'($urandom);
            sel = $urandom_range(0, 2);
            f7 = (sel == 0) ? 7'h00 : (sel == 1) ? 7'h20 : 7'($urandom);
            ins = $urandom;
            ins[31:25] = f7;
            ins[6:0] = opcs[$urandom_range(0, 9)];
            step(fsm_state_e'($urandom_range(0, 4)),
                 ($urandom_range(0, 59) == 0), ins, $urandom,
                 ($urandom_range(0, 3) != 0), 5'($urandom), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
